// File: rtl/mips_hazard_unit_if.sv
// Bundle between the pipeline core and the hazard unit: ID-stage register use,
// branch resolution, and the stall/flush/forward controls that come back.
interface mips_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              en;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              branch_taken;
    logic              stall;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              id_bypass_a;
    logic              id_bypass_b;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output en, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_reg_write, id_mem_read, branch_taken,
        input  stall, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b,
               id_bypass_a, id_bypass_b, stall_count, flush_count
    );

    modport slave (
        input  en, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_reg_write, id_mem_read, branch_taken,
        output stall, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b,
               id_bypass_a, id_bypass_b, stall_count, flush_count
    );
endinterface

// File: rtl/mips_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline; tracks register
// use of the EX/MEM/WB instructions in a shadow pipeline and counts stalls/flushes.
module mips_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int BRANCH_STAGE = 3
) (
    input logic               clk,
    input logic               rst,
    mips_hazard_unit_if.slave io_bus
);
    localparam logic             FLUSH_MEM = (BRANCH_STAGE == 3);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_ex_use_rs;
    logic              r_ex_use_rt;
    logic [REG_AW-1:0] r_ex_dest;
    logic              r_ex_rw;
    logic              r_ex_mr;
    logic [REG_AW-1:0] r_mem_dest;
    logic              r_mem_rw;
    logic              r_mem_mr;
    logic [REG_AW-1:0] r_wb_dest;
    logic              r_wb_rw;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic       w_load_use;
    logic       w_stall;
    logic       w_branch;
    logic       w_mem_src;
    logic       w_wb_src;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A taken branch squashes the dependent instruction anyway, so it wins over stall.
    assign w_load_use = r_ex_mr && r_ex_rw && (r_ex_dest != '0) &&
                        ((io_bus.id_use_rs && (io_bus.id_rs == r_ex_dest)) ||
                         (io_bus.id_use_rt && (io_bus.id_rt == r_ex_dest)));
    assign w_branch   = io_bus.en && io_bus.branch_taken;
    assign w_stall    = io_bus.en && !io_bus.branch_taken && w_load_use;

    // Loaded data is not ready in MEM; only ALU results there may be forwarded.
    assign w_mem_src  = r_mem_rw && !r_mem_mr && (r_mem_dest != '0);
    assign w_wb_src   = r_wb_rw && (r_wb_dest != '0);

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (w_mem_src && r_ex_use_rs && (r_mem_dest == r_ex_rs)) begin
            w_fwd_a = 2'b10;
        end else if (w_wb_src && r_ex_use_rs && (r_wb_dest == r_ex_rs)) begin
            w_fwd_a = 2'b01;
        end
        if (w_mem_src && r_ex_use_rt && (r_mem_dest == r_ex_rt)) begin
            w_fwd_b = 2'b10;
        end else if (w_wb_src && r_ex_use_rt && (r_wb_dest == r_ex_rt)) begin
            w_fwd_b = 2'b01;
        end
    end

    assign io_bus.stall        = w_stall;
    assign io_bus.flush_if_id  = w_branch;
    assign io_bus.flush_id_ex  = w_branch;
    assign io_bus.flush_ex_mem = w_branch && FLUSH_MEM;
    assign io_bus.fwd_a        = w_fwd_a;
    assign io_bus.fwd_b        = w_fwd_b;
    assign io_bus.id_bypass_a  = w_wb_src && io_bus.id_use_rs && (r_wb_dest == io_bus.id_rs);
    assign io_bus.id_bypass_b  = w_wb_src && io_bus.id_use_rt && (r_wb_dest == io_bus.id_rt);
    assign io_bus.stall_count  = r_stall_cnt;
    assign io_bus.flush_count  = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
            r_ex_dest   <= '0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_mem_dest  <= '0;
            r_mem_rw    <= 1'b0;
            r_mem_mr    <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_rw     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (io_bus.en) begin
            if (w_stall || io_bus.branch_taken) begin
                r_ex_rs     <= '0;
                r_ex_rt     <= '0;
                r_ex_use_rs <= 1'b0;
                r_ex_use_rt <= 1'b0;
                r_ex_dest   <= '0;
                r_ex_rw     <= 1'b0;
                r_ex_mr     <= 1'b0;
            end else begin
                r_ex_rs     <= io_bus.id_rs;
                r_ex_rt     <= io_bus.id_rt;
                r_ex_use_rs <= io_bus.id_use_rs;
                r_ex_use_rt <= io_bus.id_use_rt;
                r_ex_dest   <= io_bus.id_dest;
                r_ex_rw     <= io_bus.id_reg_write;
                r_ex_mr     <= io_bus.id_mem_read;
            end
            if (io_bus.branch_taken && FLUSH_MEM) begin
                r_mem_dest <= '0;
                r_mem_rw   <= 1'b0;
                r_mem_mr   <= 1'b0;
            end else begin
                r_mem_dest <= r_ex_dest;
                r_mem_rw   <= r_ex_rw;
                r_mem_mr   <= r_ex_mr;
            end
            r_wb_dest <= r_mem_dest;
            r_wb_rw   <= r_mem_rw;
            // Counters stick at all-ones rather than wrapping.
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (io_bus.branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_mips_hazard_unit.sv
// Scoreboard bench: directed vectors drive a BRANCH_STAGE=3/CNT_W=32 unit and a
// BRANCH_STAGE=2/CNT_W=4 unit in lockstep; a negedge monitor checks both.
module tb_mips_hazard_unit;
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
    } idT;

    typedef struct {
        string      name;
        logic [7:0] v;
        int         sc;
        int         fc;
    } expT;

    logic clk = 1'b0;
    logic rst;
    expT  q[$];
    expT  mon;
    int   nVec = 0;
    int   nFail = 0;
    int   sc = 0;
    int   fc = 0;

    always #5 clk = ~clk;

    mips_hazard_unit_if #(.REG_AW(5), .CNT_W(32)) bus3 ();
    mips_hazard_unit_if #(.REG_AW(5), .CNT_W(4))  bus2 ();

    mips_hazard_unit #(.REG_AW(5), .CNT_W(32), .BRANCH_STAGE(3)) dut3 (
        .clk(clk), .rst(rst), .io_bus(bus3)
    );
    mips_hazard_unit #(.REG_AW(5), .CNT_W(4), .BRANCH_STAGE(2)) dut2 (
        .clk(clk), .rst(rst), .io_bus(bus2)
    );

    function automatic idT mk(input int rs, input int rt, input int urs, input int urt,
                              input int dest, input int rw, input int mr);
        idT m;
        m.rs   = 5'(rs);
        m.rt   = 5'(rt);
        m.urs  = (urs != 0);
        m.urt  = (urt != 0);
        m.dest = 5'(dest);
        m.rw   = (rw != 0);
        m.mr   = (mr != 0);
        return m;
    endfunction

    // Expected bits: {stall, flush, fwd_a, fwd_b, bypass_a, bypass_b}
    function automatic logic [7:0] ex(input int s, input int f, input int fa, input int fb,
                                      input int ba, input int bb);
        return {(s != 0), (f != 0), 2'(fa), 2'(fb), (ba != 0), (bb != 0)};
    endfunction

    function automatic int sat4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic applyStimulus(input string name, input int r, input int en, input int bt,
                                 input idT id, input logic [7:0] e);
        expT rec;
        @(posedge clk);
        #1;
        rst = (r != 0);
        bus3.en = (en != 0);           bus2.en = (en != 0);
        bus3.branch_taken = (bt != 0); bus2.branch_taken = (bt != 0);
        bus3.id_rs = id.rs;            bus2.id_rs = id.rs;
        bus3.id_rt = id.rt;            bus2.id_rt = id.rt;
        bus3.id_use_rs = id.urs;       bus2.id_use_rs = id.urs;
        bus3.id_use_rt = id.urt;       bus2.id_use_rt = id.urt;
        bus3.id_dest = id.dest;        bus2.id_dest = id.dest;
        bus3.id_reg_write = id.rw;     bus2.id_reg_write = id.rw;
        bus3.id_mem_read = id.mr;      bus2.id_mem_read = id.mr;
        rec.name = name;
        rec.v    = e;
        rec.sc   = sc;
        rec.fc   = fc;
        q.push_back(rec);
        if (r != 0) begin
            sc = 0;
            fc = 0;
        end else if (en != 0) begin
            if (bt != 0) fc++;
            if (e[7]) sc++;
        end
    endtask

    task automatic checkOutput(input string name, input string tag,
                               input logic [9:0] act, input logic [9:0] expv,
                               input int aSc, input int aFc, input int eSc, input int eFc);
        nVec++;
        if (act !== expv || aSc != eSc || aFc != eFc) begin
            nFail++;
            $display("[TB] FAIL %s (%s): got ctl=%b stall_cnt=%0d flush_cnt=%0d, want ctl=%b stall_cnt=%0d flush_cnt=%0d",
                     name, tag, act, aSc, aFc, expv, eSc, eFc);
        end
    endtask

    // Monitor: every cycle that has a pending expectation, compare both units.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon = q.pop_front();
            checkOutput(mon.name, "bs3",
                {bus3.stall, bus3.flush_if_id, bus3.flush_id_ex, bus3.flush_ex_mem,
                 bus3.fwd_a, bus3.fwd_b, bus3.id_bypass_a, bus3.id_bypass_b},
                {mon.v[7], mon.v[6], mon.v[6], mon.v[6], mon.v[5:0]},
                int'(bus3.stall_count), int'(bus3.flush_count), mon.sc, mon.fc);
            checkOutput(mon.name, "bs2",
                {bus2.stall, bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_ex_mem,
                 bus2.fwd_a, bus2.fwd_b, bus2.id_bypass_a, bus2.id_bypass_b},
                {mon.v[7], mon.v[6], mon.v[6], 1'b0, mon.v[5:0]},
                int'(bus2.stall_count), int'(bus2.flush_count), sat4(mon.sc), sat4(mon.fc));
        end
    end

    initial begin
        idT nop;
        idT lw5;
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        lw5 = mk(5, 0, 1, 0, 5, 1, 1);
        rst = 1'b1;
        bus3.en = 1'b1; bus2.en = 1'b1;
        bus3.branch_taken = 1'b0; bus2.branch_taken = 1'b0;
        bus3.id_rs = '0; bus2.id_rs = '0; bus3.id_rt = '0; bus2.id_rt = '0;
        bus3.id_use_rs = 1'b0; bus2.id_use_rs = 1'b0;
        bus3.id_use_rt = 1'b0; bus2.id_use_rt = 1'b0;
        bus3.id_dest = '0; bus2.id_dest = '0;
        bus3.id_reg_write = 1'b0; bus2.id_reg_write = 1'b0;
        bus3.id_mem_read = 1'b0; bus2.id_mem_read = 1'b0;
        repeat (3) @(posedge clk);

        applyStimulus("reset_state",   0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("lu_lw20",       0, 1, 0, mk(1, 0, 1, 0, 20, 1, 1),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("lu_stall",      0, 1, 0, mk(20, 2, 1, 1, 3, 1, 0),  ex(1, 0, 0, 0, 0, 0));
        applyStimulus("lu_one_cycle",  0, 1, 0, mk(20, 2, 1, 1, 3, 1, 0),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("lu_fwd_wb",     0, 1, 0, nop,                       ex(0, 0, 1, 0, 0, 0));
        applyStimulus("alu_add13",     0, 1, 0, mk(4, 5, 1, 1, 13, 1, 0),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("alu_sub",       0, 1, 0, mk(7, 13, 1, 1, 6, 1, 0),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("alu_fwd_mem",   0, 1, 0, mk(11, 13, 1, 1, 10, 1, 0), ex(0, 0, 0, 2'b10, 0, 0));
        applyStimulus("alu_gap_fwd",   0, 1, 0, mk(13, 6, 1, 1, 0, 0, 0),  ex(0, 0, 0, 2'b01, 1, 0));
        applyStimulus("wb_fwd_b",      0, 1, 0, nop,                       ex(0, 0, 0, 2'b01, 0, 0));
        applyStimulus("dbl_addi_a",    0, 1, 0, mk(1, 0, 1, 0, 9, 1, 0),   ex(0, 0, 0, 0, 0, 0));
        applyStimulus("dbl_addi_b",    0, 1, 0, mk(2, 0, 1, 0, 9, 1, 0),   ex(0, 0, 0, 0, 0, 0));
        applyStimulus("dbl_reader",    0, 1, 0, mk(9, 9, 1, 1, 14, 1, 0),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("dbl_mem_wins",  0, 1, 0, nop,                       ex(0, 0, 2'b10, 2'b10, 0, 0));
        applyStimulus("r0_lw",         0, 1, 0, mk(1, 0, 1, 0, 0, 1, 1),   ex(0, 0, 0, 0, 0, 0));
        applyStimulus("r0_no_stall",   0, 1, 0, mk(0, 0, 1, 1, 15, 1, 0),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("r0_no_fwd_ld",  0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("r0_no_bypass",  0, 1, 0, mk(0, 15, 1, 1, 0, 1, 0),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("r0_reader",     0, 1, 0, mk(0, 0, 1, 1, 16, 1, 0),  ex(0, 0, 0, 2'b01, 0, 0));
        applyStimulus("r0_mem_dest0",  0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("r0_wb_dest0",   0, 1, 0, mk(0, 0, 1, 1, 0, 0, 0),   ex(0, 0, 0, 0, 0, 0));
        applyStimulus("r0_drain",      0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("br_lw21",       0, 1, 0, mk(1, 0, 1, 0, 21, 1, 1),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("br_over_stall", 0, 1, 1, mk(21, 0, 1, 0, 22, 1, 0), ex(0, 1, 0, 0, 0, 0));
        applyStimulus("br_drain1",     0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("br_drain2",     0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("en_lw25",       0, 1, 0, mk(1, 0, 1, 0, 25, 1, 1),  ex(0, 0, 0, 0, 0, 0));
        applyStimulus("en_low",        0, 0, 1, mk(25, 0, 1, 0, 26, 1, 0), ex(0, 0, 0, 0, 0, 0));
        applyStimulus("en_resume",     0, 1, 0, mk(25, 0, 1, 0, 26, 1, 0), ex(1, 0, 0, 0, 0, 0));
        applyStimulus("en_after",      0, 1, 0, mk(25, 0, 1, 0, 26, 1, 0), ex(0, 0, 0, 0, 0, 0));
        applyStimulus("en_fwd",        0, 1, 0, nop,                       ex(0, 0, 1, 0, 0, 0));

        // A load reading its own destination stalls every second cycle: 20 stalls.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0)
                applyStimulus("sat_loop", 0, 1, 0, lw5, ex(0, 0, 0, 0, 0, 0));
            else if (i == 1)
                applyStimulus("sat_loop", 0, 1, 0, lw5, ex(1, 0, 0, 0, 0, 0));
            else
                applyStimulus("sat_loop", 0, 1, 0, lw5, ex(1, 0, 1, 0, 1, 0));
        end

        applyStimulus("sat_check",     0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("rst_mid",       1, 1, 0, lw5,                       ex(0, 0, 0, 0, 1, 0));
        applyStimulus("rst_cleared",   0, 1, 0, lw5,                       ex(0, 0, 0, 0, 0, 0));
        applyStimulus("rst_then_stall", 0, 1, 0, lw5,                      ex(1, 0, 0, 0, 0, 0));
        applyStimulus("final",         0, 1, 0, nop,                       ex(0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            nVec++;
            nFail++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
